onebit_tx_expander: RTL and testbench

- Transmit-side inverse of the 1-bit SDR capture path: reads 16-bit density words (ones-count per 8-bit window) from a non-fallthrough async FIFO.
- Re-expands each word into an evenly spread 1-bit pattern of BITS_PER_WORD bits, two bits per clock.
- Output pair drives an ODDR feeding a TLVDS_OBUF; runs in the 144 MHz data clock domain.

---
 rtl/onebit_tx_pkg.sv | 21 ++
 rtl/onebit_pattern_gen.sv | 41 ++++
 rtl/onebit_tx_expander.sv | 183 ++++++++++++++++++
 tb/tb_onebit_tx_expander.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onebit_tx_pkg.sv
// onebit_tx_pkg: shared constants for the 1-bit transmit expander.
// Holds the FSM state encoding and the default frame geometry
// (N bits per word, P = N/2 clocks per frame, FIFO read issued at phase P-2).
package onebit_tx_pkg;

   // FSM state encoding (legacy-compatible plain constants)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRIME = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   // Default frame geometry
   localparam int DEF_BITS_PER_WORD = 8;
   localparam int DEF_FRAME_CLKS    = DEF_BITS_PER_WORD / 2;
   localparam int DEF_READ_PHASE    = DEF_FRAME_CLKS - 2;

   // Clocks per frame for a given bits-per-word (two bits leave per clock)
   function automatic int frame_clks(input int bits_per_word);
      return bits_per_word / 2;
   endfunction

endpackage

// File: rtl/onebit_pattern_gen.sv
// onebit_pattern_gen: combinational bit-pair generator.
// For count c and phase p it returns bits k=2p and k=2p+1 of the evenly
// spread pattern bit(k) = floor((k+1)c/N) - floor(kc/N), which places
// exactly c ones across N bits. With c <= N each difference is 0 or 1.
module onebit_pattern_gen
   import onebit_tx_pkg::*;
#(
   parameter int BITS_PER_WORD = DEF_BITS_PER_WORD,
   parameter int CNT_W         = $clog2(BITS_PER_WORD + 1),
   parameter int PH_W          = (frame_clks(BITS_PER_WORD) > 1) ? $clog2(frame_clks(BITS_PER_WORD)) : 1
) (
   input  logic [CNT_W-1:0] count,
   input  logic [PH_W-1:0]  phase,
   output logic             bit0,
   output logic             bit1
);

   // Bit index width holds 0..N, product width holds N*N
   localparam int K_W    = $clog2(BITS_PER_WORD + 1);
   localparam int PROD_W = K_W + CNT_W;

   logic [K_W-1:0]    k_lo;
   logic [K_W-1:0]    k_mid;
   logic [K_W-1:0]    k_hi;
   logic [PROD_W-1:0] q_lo;
   logic [PROD_W-1:0] q_mid;
   logic [PROD_W-1:0] q_hi;

   // Three cumulative ones counts bound the two bits of this phase
   always_comb begin
      k_lo  = K_W'({phase, 1'b0});
      k_mid = K_W'({phase, 1'b1});
      k_hi  = k_lo + K_W'(2);
      q_lo  = (PROD_W'(k_lo)  * PROD_W'(count)) / PROD_W'(BITS_PER_WORD);
      q_mid = (PROD_W'(k_mid) * PROD_W'(count)) / PROD_W'(BITS_PER_WORD);
      q_hi  = (PROD_W'(k_hi)  * PROD_W'(count)) / PROD_W'(BITS_PER_WORD);
      bit0  = (q_mid != q_lo);
      bit1  = (q_hi != q_mid);
   end

endmodule

// File: rtl/onebit_tx_expander.sv
// onebit_tx_expander: re-expands 16-bit density words from a non-fallthrough
// FIFO into an evenly spread 1-bit stream, two bits per clk_data cycle, for
// an ODDR (tx_q0 -> D0, tx_q1 -> D1).
// Handshake: fifo_read_en is a combinational strobe, raised only when
// fifo_empty is low; data_in is valid (and captured) in the cycle after it.
// Optional build macro ONEBIT_TX_STATS_EN adds word_count and underflow_count.
module onebit_tx_expander
   import onebit_tx_pkg::*;
#(
   parameter int DSIZE         = 16,
   parameter int BITS_PER_WORD = DEF_BITS_PER_WORD,
   parameter int CNT_W         = $clog2(BITS_PER_WORD + 1)
) (
   input  logic             clk_data,
   input  logic             rst,
   input  logic             fifo_empty,
   output logic             fifo_read_en,
   input  logic [DSIZE-1:0] data_in,
   output logic             tx_q0,
   output logic             tx_q1,
   output logic             active,
   output logic             underflow,
   output logic             saturated,
   output logic [1:0]       state_dbg
`ifdef ONEBIT_TX_STATS_EN
   ,
   output logic [31:0]      word_count,
   output logic [15:0]      underflow_count
`endif
);

   localparam int FRAME_CLKS = frame_clks(BITS_PER_WORD);
   localparam int PH_W       = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
   localparam logic [PH_W-1:0] READ_PHASE = PH_W'(FRAME_CLKS - 2);
   localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(FRAME_CLKS - 1);

   logic [1:0]       state;
   logic [PH_W-1:0]  phase;
   logic [CNT_W-1:0] cur_count;
   logic             pending;

   logic [CNT_W-1:0] cnt_field;
   logic [CNT_W-1:0] cnt_clamped;
   logic             cnt_over;
   logic             frame_end;
   logic             load_evt;
   logic             underflow_evt;
   logic             pat_bit0;
   logic             pat_bit1;
   logic             unused_data_hi;

   // Only the low count field carries information; the rest is ignored
   assign cnt_field      = data_in[CNT_W-1:0];
   assign unused_data_hi = ^data_in[DSIZE-1:CNT_W];

   // Clamp the count field to N so a frame never carries more than N ones
   always_comb begin
      cnt_over    = (cnt_field > CNT_W'(BITS_PER_WORD));
      cnt_clamped = cnt_over ? CNT_W'(BITS_PER_WORD) : cnt_field;
   end

   // Frame-boundary events: a reload (prefetched word present) or an underflow
   always_comb begin
      frame_end     = (state == ST_RUN) && (phase == LAST_PHASE);
      load_evt      = (state == ST_PRIME) || (frame_end && pending);
      underflow_evt = frame_end && !pending;
   end

   // Read strobe: any time in IDLE, or once per frame at the prefetch phase
   always_comb begin
      fifo_read_en = 1'b0;
      if (!rst) begin
         if (state == ST_IDLE) begin
            fifo_read_en = !fifo_empty;
         end else if ((state == ST_RUN) && (phase == READ_PHASE)) begin
            fifo_read_en = !fifo_empty;
         end
      end
   end

   // Control FSM: IDLE -> PRIME (capture word) -> RUN (frames back to back)
   always_ff @(posedge clk_data) begin
      if (rst) begin
         state     <= ST_IDLE;
         phase     <= '0;
         cur_count <= '0;
         pending   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fifo_read_en) begin
                  state <= ST_PRIME;
               end
            end
            ST_PRIME: begin
               cur_count <= cnt_clamped;
               phase     <= '0;
               state     <= ST_RUN;
            end
            ST_RUN: begin
               if (phase == READ_PHASE) begin
                  pending <= fifo_read_en;
               end
               if (phase == LAST_PHASE) begin
                  phase   <= '0;
                  pending <= 1'b0;
                  if (pending) begin
                     cur_count <= cnt_clamped;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   onebit_pattern_gen #(
      .BITS_PER_WORD (BITS_PER_WORD),
      .CNT_W         (CNT_W),
      .PH_W          (PH_W)
   ) u_pattern_gen (
      .count (cur_count),
      .phase (phase),
      .bit0  (pat_bit0),
      .bit1  (pat_bit1)
   );

   // Registered bit pair for the ODDR; forced low whenever not in RUN
   always_ff @(posedge clk_data) begin
      if (rst) begin
         tx_q0 <= 1'b0;
         tx_q1 <= 1'b0;
      end else if (state == ST_RUN) begin
         tx_q0 <= pat_bit0;
         tx_q1 <= pat_bit1;
      end else begin
         tx_q0 <= 1'b0;
         tx_q1 <= 1'b0;
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk_data) begin
      if (rst) begin
         underflow <= 1'b0;
         saturated <= 1'b0;
      end else begin
         if (underflow_evt) begin
            underflow <= 1'b1;
         end
         if (load_evt && cnt_over) begin
            saturated <= 1'b1;
         end
      end
   end

   assign active    = (state == ST_RUN);
   assign state_dbg = state;

`ifdef ONEBIT_TX_STATS_EN
   // Statistics: wrapping word counter and saturating underflow counter
   always_ff @(posedge clk_data) begin
      if (rst) begin
         word_count      <= '0;
         underflow_count <= '0;
      end else begin
         if (load_evt) begin
            word_count <= word_count + 32'd1;
         end
         if (underflow_evt && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_onebit_tx_expander.sv
// tb_onebit_tx_expander: self-checking bench for onebit_tx_expander.
// A queue-based FIFO model feeds the DUT; expected bit pairs are pushed
// when words are queued and popped when the DUT emits a frame pair.
// Build with ONEBIT_TX_STATS_EN defined to exercise the statistics outputs.
module tb_onebit_tx_expander;

   localparam int N     = 8;
   localparam int P     = N / 2;
   localparam int DSIZE = 16;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRIME = 2'd1;

   // ---------------- clock / reset ----------------
   logic             clk_data = 1'b0;
   logic             rst = 1'b1;
   logic             fifo_empty = 1'b1;
   logic             fifo_read_en;
   logic [DSIZE-1:0] data_in = '0;
   logic             tx_q0;
   logic             tx_q1;
   logic             active;
   logic             underflow;
   logic             saturated;
   logic [1:0]       state_dbg;
`ifdef ONEBIT_TX_STATS_EN
   logic [31:0]      word_count;
   logic [15:0]      underflow_count;
`endif

   always #5 clk_data = ~clk_data;

   onebit_tx_expander #(
      .DSIZE         (DSIZE),
      .BITS_PER_WORD (N)
   ) dut (
      .clk_data        (clk_data),
      .rst             (rst),
      .fifo_empty      (fifo_empty),
      .fifo_read_en    (fifo_read_en),
      .data_in         (data_in),
      .tx_q0           (tx_q0),
      .tx_q1           (tx_q1),
      .active          (active),
      .underflow       (underflow),
      .saturated       (saturated),
      .state_dbg       (state_dbg)
`ifdef ONEBIT_TX_STATS_EN
      ,
      .word_count      (word_count),
      .underflow_count (underflow_count)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- FIFO model ----------------
   logic [DSIZE-1:0] fifo_q[$];
   logic             hold_empty = 1'b0;
   event             fifo_kick;

   always @(negedge clk_data or fifo_kick) begin
      fifo_empty = hold_empty || (fifo_q.size() == 0);
   end

   always @(posedge clk_data) begin
      if (fifo_read_en && (fifo_q.size() > 0)) begin
         data_in <= fifo_q.pop_front();
      end
   end

   // ---------------- reference model ----------------
   function automatic int clamp_cnt(input logic [DSIZE-1:0] w);
      int c;
      c = int'(w[3:0]);
      return (c > N) ? N : c;
   endfunction

   function automatic logic ref_bit(input int c, input int k);
      return (((k + 1) * c) / N - (k * c) / N) != 0;
   endfunction

   // ---------------- scoreboard ----------------
   logic [1:0] exp_q[$];
   logic [1:0] exp_pair;
   logic       act_d = 1'b0;
   logic       mon_en = 1'b0;

   always @(posedge clk_data) act_d <= rst ? 1'b0 : active;

   always @(negedge clk_data) begin
      if (mon_en) begin
         n_cmp++;
         if (act_d) begin
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL scoreboard_extra: got pair %b, required no output", {tx_q0, tx_q1});
            end else begin
               exp_pair = exp_q.pop_front();
               if ({tx_q0, tx_q1} !== exp_pair) begin
                  n_err++;
                  $display("FAIL frame_pair: got %b, required %b", {tx_q0, tx_q1}, exp_pair);
               end
            end
         end else if ({tx_q0, tx_q1} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_zero: got %b, required 00", {tx_q0, tx_q1});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_exp(input logic [DSIZE-1:0] w);
      int c;
      c = clamp_cnt(w);
      for (int p = 0; p < P; p++) begin
         exp_q.push_back({ref_bit(c, 2 * p), ref_bit(c, 2 * p + 1)});
      end
   endtask

   task automatic push_word(input logic [DSIZE-1:0] w, input bit with_exp);
      fifo_q.push_back(w);
      if (with_exp) push_exp(w);
      -> fifo_kick;
   endtask

   task automatic do_reset();
      @(negedge clk_data);
      rst = 1'b1;
      repeat (2) @(negedge clk_data);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         @(negedge clk_data);
         #1;
         if (!active && (exp_q.size() == 0)) done = 1'b1;
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL drain_timeout: active=%b pending=%0d, required idle with 0 pending", active, exp_q.size());
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      push_word(16'h0004, 1'b0);
      repeat (2) @(negedge clk_data);
      #1;
      n_cmp++;
      if (fifo_read_en !== 1'b0) begin n_err++; $display("FAIL reset_read_en: got %b, required 0", fifo_read_en); end
      n_cmp++;
      if (state_dbg !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", state_dbg, S_IDLE); end
      n_cmp++;
      if ({tx_q0, tx_q1, active} !== 3'b000) begin n_err++; $display("FAIL reset_outputs: got %b, required 000", {tx_q0, tx_q1, active}); end
      n_cmp++;
      if ({underflow, saturated} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b, required 00", {underflow, saturated}); end
      fifo_q.delete();
      -> fifo_kick;
      @(negedge clk_data);
      rst = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_empty_hold();
      hold_empty = 1'b1;
      push_word(16'h0005, 1'b0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_data);
         #1;
         n_cmp++;
         if ({fifo_read_en, active} !== 2'b00) begin n_err++; $display("FAIL empty_hold_idle: rd/active got %b, required 00", {fifo_read_en, active}); end
      end
      n_cmp++;
      if ({underflow, saturated} !== 2'b00) begin n_err++; $display("FAIL empty_hold_flags: got %b, required 00", {underflow, saturated}); end
      fifo_q.delete();
      hold_empty = 1'b0;
      -> fifo_kick;
      @(negedge clk_data);
   endtask

   task automatic test_single_word();
      @(negedge clk_data);
      push_word(16'h0004, 1'b1);
      #1;
      n_cmp++;
      if (fifo_read_en !== 1'b1) begin n_err++; $display("FAIL single_strobe: got %b, required 1", fifo_read_en); end
      @(negedge clk_data); #1;
      n_cmp++;
      if ({fifo_read_en, active, state_dbg} !== {2'b00, S_PRIME}) begin n_err++; $display("FAIL single_prime: got %b, required 0001", {fifo_read_en, active, state_dbg}); end
      @(negedge clk_data); #1;
      n_cmp++;
      if ({active, tx_q0, tx_q1} !== 3'b100) begin n_err++; $display("FAIL single_run_start: got %b, required 100", {active, tx_q0, tx_q1}); end
      @(negedge clk_data); #1;
      n_cmp++;
      if ({tx_q0, tx_q1} !== 2'b01) begin n_err++; $display("FAIL single_first_pair: got %b, required 01", {tx_q0, tx_q1}); end
      wait_idle(20);
      n_cmp++;
      if ({underflow, state_dbg} !== {1'b1, S_IDLE}) begin n_err++; $display("FAIL single_underflow: got %b, required 100", {underflow, state_dbg}); end
      @(negedge clk_data); #1;
      n_cmp++;
      if ({tx_q0, tx_q1} !== 2'b00) begin n_err++; $display("FAIL single_after: got %b, required 00", {tx_q0, tx_q1}); end
   endtask

   task automatic test_saturate();
      do_reset();
      push_word(16'h000F, 1'b1);
      push_word(16'hFF03, 1'b1);
      repeat (2) @(negedge clk_data);
      #1;
      n_cmp++;
      if ({saturated, underflow} !== 2'b10) begin n_err++; $display("FAIL sat_flag: got %b, required 10", {saturated, underflow}); end
      repeat (4) @(negedge clk_data);
      #1;
      n_cmp++;
      if ({active, saturated, underflow} !== 3'b110) begin n_err++; $display("FAIL sat_frame2: got %b, required 110", {active, saturated, underflow}); end
      wait_idle(30);
      n_cmp++;
      if ({saturated, underflow} !== 2'b11) begin n_err++; $display("FAIL sat_end_flags: got %b, required 11", {saturated, underflow}); end
   endtask

   task automatic test_back_to_back();
      logic exp_rd;
      logic exp_act;
      do_reset();
      push_word(16'h0008, 1'b1);
      push_word(16'h0000, 1'b1);
      push_word(16'h0002, 1'b1);
      for (int off = 0; off < 15; off++) begin
         if (off != 0) @(negedge clk_data);
         #1;
         exp_rd  = (off == 0) || (off == 4) || (off == 8);
         exp_act = (off >= 2) && (off <= 13);
         n_cmp++;
         if (fifo_read_en !== exp_rd) begin n_err++; $display("FAIL stream_read_en @%0d: got %b, required %b", off, fifo_read_en, exp_rd); end
         n_cmp++;
         if (active !== exp_act) begin n_err++; $display("FAIL stream_active @%0d: got %b, required %b", off, active, exp_act); end
         n_cmp++;
         if (underflow !== (off >= 14)) begin n_err++; $display("FAIL stream_underflow @%0d: got %b, required %b", off, underflow, (off >= 14)); end
      end
      wait_idle(10);
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk_data);
      push_word(16'h0006, 1'b1);
      push_word(16'h0003, 1'b0);
      repeat (3) @(negedge clk_data);
      rst = 1'b1;
      @(negedge clk_data);
      #1;
      n_cmp++;
      if (fifo_read_en !== 1'b0) begin n_err++; $display("FAIL midrst_read_en: got %b, required 0", fifo_read_en); end
      n_cmp++;
      if ({state_dbg, active, tx_q0, tx_q1} !== {S_IDLE, 3'b000}) begin n_err++; $display("FAIL midrst_state: got %b, required 00000", {state_dbg, active, tx_q0, tx_q1}); end
      n_cmp++;
      if ({underflow, saturated} !== 2'b00) begin n_err++; $display("FAIL midrst_flags: got %b, required 00", {underflow, saturated}); end
      exp_q.delete();
      push_exp(16'h0003);
      @(negedge clk_data);
      rst = 1'b0;
      wait_idle(30);
      n_cmp++;
      if (underflow !== 1'b1) begin n_err++; $display("FAIL midrst_restart_underflow: got %b, required 1", underflow); end
   endtask

`ifdef ONEBIT_TX_STATS_EN
   task automatic test_stats();
      do_reset();
      #1;
      n_cmp++;
      if ({word_count, underflow_count} !== 48'd0) begin n_err++; $display("FAIL stats_reset: got %0d/%0d, required 0/0", word_count, underflow_count); end
      for (int i = 0; i < 5; i++) push_word(DSIZE'($urandom_range(0, 15)), 1'b1);
      wait_idle(60);
      n_cmp++;
      if (word_count !== 32'd5) begin n_err++; $display("FAIL stats_words: got %0d, required 5", word_count); end
      n_cmp++;
      if (underflow_count !== 16'd1) begin n_err++; $display("FAIL stats_underflows: got %0d, required 1", underflow_count); end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_empty_hold();
      test_single_word();
      test_saturate();
      test_back_to_back();
      test_reset_mid_frame();
      for (int i = 0; i < 3; i++) begin
         do_reset();
         push_word(DSIZE'($urandom_range(0, 15)), 1'b1);
         push_word(DSIZE'($urandom_range(0, 15)), 1'b1);
         wait_idle(40);
      end
`ifdef ONEBIT_TX_STATS_EN
      test_stats();
`endif
      repeat (2) @(negedge clk_data);
      n_cmp++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
